// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing a small synchronous memory between a CPU port and a DMA/loader port.
// CPU-first fixed priority with a DMA starvation guard, optional bus lock and address window check.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [7:0]        cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [15:0]       dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [7:0]        dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              oor_err
);

  typedef enum logic [1:0] {OwnNone, OwnCpu, OwnDma} owner_e;

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  owner_e      owner_q, owner_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        cpu_rvalid_q, dma_rvalid_q;
  // Marks the outstanding response (or the just-finished access) as out of range.
  logic        oor_q;

  logic        any_gnt;
  logic        in_range;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [7:0]  sel_wdata;

  // Grant decision; everything is forced idle while reset is held.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (rst) begin
      case (owner_q)
        OwnCpu: cpu_gnt = cpu_req;
        OwnDma: dma_gnt = dma_req;
        default: begin
          if (cpu_req && dma_req) begin
            if (wait_cnt_q == MaxWait) dma_gnt = 1'b1;
            else                       cpu_gnt = 1'b1;
          end else begin
            cpu_gnt = cpu_req;
            dma_gnt = dma_req;
          end
        end
      endcase
    end
  end

  always_comb begin
    any_gnt   = cpu_gnt | dma_gnt;
    sel_addr  = dma_gnt ? dma_addr  : cpu_addr;
    sel_we    = dma_gnt ? dma_we    : cpu_we;
    sel_wdata = dma_gnt ? dma_wdata : cpu_wdata;
    in_range  = (sel_addr[15:ADDR_W] == '0);
    // Out-of-range accesses are granted but never reach the memory.
    mem_en    = any_gnt && in_range;
    mem_we    = mem_en && sel_we;
    mem_addr  = mem_en ? sel_addr[ADDR_W-1:0] : '0;
    mem_wdata = mem_en ? sel_wdata : '0;
  end

  always_comb begin
    owner_d = owner_q;
    case (owner_q)
      OwnCpu:  if (!cpu_lock) owner_d = OwnNone;
      OwnDma:  if (!dma_lock) owner_d = OwnNone;
      default: begin
        if (cpu_gnt && cpu_lock)      owner_d = OwnCpu;
        else if (dma_gnt && dma_lock) owner_d = OwnDma;
      end
    endcase

    wait_cnt_d = wait_cnt_q;
    if (dma_gnt)                               wait_cnt_d = '0;
    else if (dma_req && wait_cnt_q < MaxWait)  wait_cnt_d = wait_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q      <= OwnNone;
      wait_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      oor_q        <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      wait_cnt_q   <= wait_cnt_d;
      cpu_rvalid_q <= cpu_gnt && !cpu_we;
      dma_rvalid_q <= dma_gnt && !dma_we;
      oor_q        <= any_gnt && !in_range;
    end
  end

  always_comb begin
    cpu_rvalid = cpu_rvalid_q;
    dma_rvalid = dma_rvalid_q;
    cpu_rdata  = (cpu_rvalid_q && !oor_q) ? mem_rdata : 8'h00;
    dma_rdata  = (dma_rvalid_q && !oor_q) ? mem_rdata : 8'h00;
    oor_err    = oor_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a behavioural model of the arbitration rules and a shadow memory.
module tb_mem_arbiter;

  localparam int ADDR_W   = 9;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cpu_req, cpu_we, cpu_lock;
  logic [15:0]       cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_gnt, cpu_rvalid;
  logic [7:0]        cpu_rdata;
  logic              dma_req, dma_we, dma_lock;
  logic [15:0]       dma_addr;
  logic [7:0]        dma_wdata;
  logic              dma_gnt, dma_rvalid;
  logic [7:0]        dma_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              oor_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory device and its shadow copy kept by the bench.
  logic [7:0] mem [512];
  logic [7:0] ref_mem [512];
  logic       init_mem = 1'b0;

  // Model state for the randomized test.
  int         m_owner;   // 0 none, 1 cpu, 2 dma
  int         m_wait;    // cycles the DMA has been requesting without a grant
  int         m_unl;     // of those, cycles with no owner holding the bus
  bit         pend_c, pend_d, pend_oor;
  logic [7:0] pend_data;

  mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .oor_err(oor_err)
  );

  always #5 clk = ~clk;

  // 0xEE on idle cycles so a leaked read bus is visible.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'(i * 37 + 11);
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= (mem_en && !mem_we) ? mem[mem_addr] : 8'hEE;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    cpu_req = 1'b1;
    dma_req = 1'b1;
    init_mem = 1'b1;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'(i * 37 + 11);
    next_cycle();
    init_mem = 1'b0;
    @(negedge clk);
    n_checks++; if (cpu_gnt !== 1'b0) $display("FAIL reset_cpu_gnt: got %b want 0", cpu_gnt); else n_pass++;
    n_checks++; if (dma_gnt !== 1'b0) $display("FAIL reset_dma_gnt: got %b want 0", dma_gnt); else n_pass++;
    n_checks++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b want 0", mem_en); else n_pass++;
    n_checks++; if (cpu_rvalid !== 1'b0) $display("FAIL reset_cpu_rvalid: got %b want 0", cpu_rvalid); else n_pass++;
    n_checks++; if (dma_rvalid !== 1'b0) $display("FAIL reset_dma_rvalid: got %b want 0", dma_rvalid); else n_pass++;
    n_checks++; if (oor_err !== 1'b0) $display("FAIL reset_oor_err: got %b want 0", oor_err); else n_pass++;
    n_checks++; if (cpu_rdata !== 8'h00) $display("FAIL reset_cpu_rdata: got %h want 00", cpu_rdata); else n_pass++;
    idle_inputs();
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_cpu_read();
    // Seed memory[0xA0] = 3C through the DMA port.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h00A0; dma_wdata = 8'h3C;
    @(negedge clk);
    n_checks++; if (dma_gnt !== 1'b1) $display("FAIL seed_dma_gnt: got %b want 1", dma_gnt); else n_pass++;
    n_checks++; if (mem_we !== 1'b1) $display("FAIL seed_mem_we: got %b want 1", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 9'h0A0) $display("FAIL seed_mem_addr: got %h want 0a0", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 8'h3C) $display("FAIL seed_mem_wdata: got %h want 3c", mem_wdata); else n_pass++;
    ref_mem[9'h0A0] = 8'h3C;
    next_cycle();
    idle_inputs();
    cpu_req = 1'b1; cpu_addr = 16'h00A0;
    @(negedge clk);
    n_checks++; if (cpu_gnt !== 1'b1) $display("FAIL rd_cpu_gnt: got %b want 1", cpu_gnt); else n_pass++;
    n_checks++; if (mem_en !== 1'b1) $display("FAIL rd_mem_en: got %b want 1", mem_en); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL rd_mem_we: got %b want 0", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 9'h0A0) $display("FAIL rd_mem_addr: got %h want 0a0", mem_addr); else n_pass++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (cpu_rvalid !== 1'b1) $display("FAIL rd_cpu_rvalid: got %b want 1", cpu_rvalid); else n_pass++;
    n_checks++; if (cpu_rdata !== 8'h3C) $display("FAIL rd_cpu_rdata: got %h want 3c", cpu_rdata); else n_pass++;
    n_checks++; if (dma_rvalid !== 1'b0) $display("FAIL rd_dma_rvalid: got %b want 0", dma_rvalid); else n_pass++;
    n_checks++; if (oor_err !== 1'b0) $display("FAIL rd_oor_err: got %b want 0", oor_err); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++; if (cpu_rvalid !== 1'b0) $display("FAIL rd_rvalid_drop: got %b want 0", cpu_rvalid); else n_pass++;
    n_checks++; if (cpu_rdata !== 8'h00) $display("FAIL rd_rdata_idle: got %h want 00", cpu_rdata); else n_pass++;
    next_cycle();
  endtask

  task automatic test_contention();
    bit prev_d;
    bit exp_d;
    prev_d = 1'b0;
    cpu_req = 1'b1; cpu_addr = 16'h0001;
    dma_req = 1'b1; dma_addr = 16'h0002;
    for (int c = 0; c < 10; c++) begin
      exp_d = (c == MAX_WAIT) || (c == 2 * MAX_WAIT + 1);
      @(negedge clk);
      n_checks++; if (cpu_gnt !== !exp_d) $display("FAIL cont_cpu_gnt c%0d: got %b want %b", c, cpu_gnt, !exp_d); else n_pass++;
      n_checks++; if (dma_gnt !== exp_d) $display("FAIL cont_dma_gnt c%0d: got %b want %b", c, dma_gnt, exp_d); else n_pass++;
      if (c > 0) begin
        n_checks++;
        if (dma_rvalid !== prev_d || dma_rdata !== (prev_d ? ref_mem[2] : 8'h00))
          $display("FAIL cont_dma_resp c%0d: got %b/%h want %b/%h", c, dma_rvalid, dma_rdata,
                   prev_d, prev_d ? ref_mem[2] : 8'h00);
        else n_pass++;
        n_checks++;
        if (cpu_rvalid !== !prev_d || cpu_rdata !== (prev_d ? 8'h00 : ref_mem[1]))
          $display("FAIL cont_cpu_resp c%0d: got %b/%h want %b/%h", c, cpu_rvalid, cpu_rdata,
                   !prev_d, prev_d ? 8'h00 : ref_mem[1]);
        else n_pass++;
      end
      prev_d = exp_d;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_lock();
    dma_req = 1'b1; dma_we = 1'b1; dma_lock = 1'b1; dma_addr = 16'h0010; dma_wdata = 8'h11;
    @(negedge clk);
    n_checks++; if (dma_gnt !== 1'b1) $display("FAIL lock_c0_dma_gnt: got %b want 1", dma_gnt); else n_pass++;
    ref_mem[9'h010] = 8'h11;
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 16'h0010; dma_wdata = 8'h5A;
    @(negedge clk);
    n_checks++; if (cpu_gnt !== 1'b0) $display("FAIL lock_c1_cpu_gnt: got %b want 0", cpu_gnt); else n_pass++;
    n_checks++; if (dma_gnt !== 1'b1) $display("FAIL lock_c1_dma_gnt: got %b want 1", dma_gnt); else n_pass++;
    n_checks++; if (mem_wdata !== 8'h5A) $display("FAIL lock_c1_wdata: got %h want 5a", mem_wdata); else n_pass++;
    ref_mem[9'h010] = 8'h5A;
    next_cycle();
    dma_req = 1'b0;
    @(negedge clk);
    n_checks++; if (cpu_gnt !== 1'b0) $display("FAIL lock_hold_cpu_gnt: got %b want 0", cpu_gnt); else n_pass++;
    n_checks++; if (mem_en !== 1'b0) $display("FAIL lock_hold_mem_en: got %b want 0", mem_en); else n_pass++;
    next_cycle();
    dma_lock = 1'b0;
    @(negedge clk);
    n_checks++; if (cpu_gnt !== 1'b0) $display("FAIL lock_release_cpu_gnt: got %b want 0", cpu_gnt); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++; if (cpu_gnt !== 1'b1) $display("FAIL lock_after_cpu_gnt: got %b want 1", cpu_gnt); else n_pass++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (cpu_rvalid !== 1'b1) $display("FAIL lock_rd_rvalid: got %b want 1", cpu_rvalid); else n_pass++;
    n_checks++; if (cpu_rdata !== 8'h5A) $display("FAIL lock_rd_rdata: got %h want 5a", cpu_rdata); else n_pass++;
    next_cycle();
  endtask

  task automatic test_oor();
    cpu_req = 1'b1; cpu_addr = 16'h0200;
    @(negedge clk);
    n_checks++; if (cpu_gnt !== 1'b1) $display("FAIL oor_cpu_gnt: got %b want 1", cpu_gnt); else n_pass++;
    n_checks++; if (mem_en !== 1'b0) $display("FAIL oor_mem_en: got %b want 0", mem_en); else n_pass++;
    n_checks++; if (mem_addr !== 9'h000) $display("FAIL oor_mem_addr: got %h want 000", mem_addr); else n_pass++;
    next_cycle();
    idle_inputs();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h8010; dma_wdata = 8'h77;
    @(negedge clk);
    n_checks++; if (cpu_rvalid !== 1'b1) $display("FAIL oor_rvalid: got %b want 1", cpu_rvalid); else n_pass++;
    n_checks++; if (cpu_rdata !== 8'h00) $display("FAIL oor_rdata: got %h want 00", cpu_rdata); else n_pass++;
    n_checks++; if (oor_err !== 1'b1) $display("FAIL oor_err_rd: got %b want 1", oor_err); else n_pass++;
    n_checks++; if (dma_gnt !== 1'b1) $display("FAIL oor_wr_gnt: got %b want 1", dma_gnt); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL oor_wr_mem_we: got %b want 0", mem_we); else n_pass++;
    next_cycle();
    dma_we = 1'b0; dma_addr = 16'h0010;
    @(negedge clk);
    n_checks++; if (oor_err !== 1'b1) $display("FAIL oor_err_wr: got %b want 1", oor_err); else n_pass++;
    n_checks++; if (dma_rvalid !== 1'b0) $display("FAIL oor_wr_no_rvalid: got %b want 0", dma_rvalid); else n_pass++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (dma_rdata !== 8'h5A) $display("FAIL oor_write_dropped: got %h want 5a", dma_rdata); else n_pass++;
    n_checks++; if (oor_err !== 1'b0) $display("FAIL oor_err_clear: got %b want 0", oor_err); else n_pass++;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    // Build up DMA waiting, then reset while a CPU read is granted.
    cpu_req = 1'b1; cpu_addr = 16'h00A0;
    dma_req = 1'b1; dma_addr = 16'h0010;
    for (int c = 0; c < MAX_WAIT; c++) begin
      @(negedge clk);
      n_checks++; if (cpu_gnt !== 1'b1) $display("FAIL rstm_pre_gnt c%0d: got %b want 1", c, cpu_gnt); else n_pass++;
      next_cycle();
    end
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (cpu_gnt !== 1'b0 || dma_gnt !== 1'b0) $display("FAIL rstm_gnt_low: got %b%b want 00", cpu_gnt, dma_gnt); else n_pass++;
    n_checks++; if (mem_en !== 1'b0) $display("FAIL rstm_mem_en: got %b want 0", mem_en); else n_pass++;
    n_checks++; if (cpu_rvalid !== 1'b0) $display("FAIL rstm_rvalid_clr: got %b want 0", cpu_rvalid); else n_pass++;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) $display("FAIL rstm_wait_clr: got %b%b want 10", cpu_gnt, dma_gnt); else n_pass++;
    n_checks++; if (cpu_rvalid !== 1'b0) $display("FAIL rstm_no_rvalid: got %b want 0", cpu_rvalid); else n_pass++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h3C) $display("FAIL rstm_first_rd: got %b/%h want 1/3c", cpu_rvalid, cpu_rdata); else n_pass++;
    next_cycle();
    // Reset must also release a locked owner.
    dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 16'h0010;
    @(negedge clk);
    n_checks++; if (dma_gnt !== 1'b1) $display("FAIL rstm_lock_gnt: got %b want 1", dma_gnt); else n_pass++;
    next_cycle();
    dma_req = 1'b0;
    #1 rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++; if (dma_rvalid !== 1'b0 || dma_rdata !== 8'h00) $display("FAIL rstm_dma_resp_clr: got %b/%h want 0/00", dma_rvalid, dma_rdata); else n_pass++;
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 16'h00A0;
    @(negedge clk);
    n_checks++; if (cpu_gnt !== 1'b1) $display("FAIL rstm_owner_clr: got %b want 1", cpu_gnt); else n_pass++;
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    if ($urandom_range(0, 15) == 0) a = {7'($urandom_range(1, 127)), 9'($urandom)};
    else                            a = {7'd0, 9'($urandom)};
    return a;
  endfunction

  task automatic test_random();
    bit          cg, dg, exp_en, exp_we, inr;
    logic [15:0] a;
    bit          c_stall, d_stall;
    idle_inputs();
    rst = 1'b0;
    #1 rst = 1'b1;
    m_owner = 0; m_wait = 0; m_unl = 0;
    pend_c = 0; pend_d = 0; pend_oor = 0; pend_data = 8'h00;
    c_stall = 0; d_stall = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!c_stall) begin
        cpu_req = ($urandom_range(0, 9) < 7); cpu_we = ($urandom_range(0, 2) == 0);
        cpu_lock = ($urandom_range(0, 7) == 0); cpu_addr = rand_addr(); cpu_wdata = 8'($urandom);
      end
      if (!d_stall) begin
        dma_req = ($urandom_range(0, 9) < 6); dma_we = ($urandom_range(0, 2) == 0);
        dma_lock = ($urandom_range(0, 7) == 0); dma_addr = rand_addr(); dma_wdata = 8'($urandom);
      end
      // Arbitration rules applied to the model state.
      cg = 0; dg = 0;
      if (m_owner == 1)                 cg = cpu_req;
      else if (m_owner == 2)            dg = dma_req;
      else if (cpu_req && dma_req)      begin if (m_wait >= MAX_WAIT) dg = 1; else cg = 1; end
      else                              begin cg = cpu_req; dg = dma_req; end
      a = dg ? dma_addr : cpu_addr;
      inr = (a[15:9] == 7'd0);
      exp_en = (cg || dg) && inr;
      exp_we = exp_en && (dg ? dma_we : cpu_we);
      @(negedge clk);
      n_checks++; if (cpu_gnt !== cg) $display("FAIL rnd_cpu_gnt cyc%0d: got %b want %b", cyc, cpu_gnt, cg); else n_pass++;
      n_checks++; if (dma_gnt !== dg) $display("FAIL rnd_dma_gnt cyc%0d: got %b want %b", cyc, dma_gnt, dg); else n_pass++;
      n_checks++; if (mem_en !== exp_en) $display("FAIL rnd_mem_en cyc%0d: got %b want %b", cyc, mem_en, exp_en); else n_pass++;
      n_checks++; if (mem_we !== exp_we) $display("FAIL rnd_mem_we cyc%0d: got %b want %b", cyc, mem_we, exp_we); else n_pass++;
      n_checks++; if (cpu_rvalid !== pend_c) $display("FAIL rnd_cpu_rvalid cyc%0d: got %b want %b", cyc, cpu_rvalid, pend_c); else n_pass++;
      n_checks++; if (dma_rvalid !== pend_d) $display("FAIL rnd_dma_rvalid cyc%0d: got %b want %b", cyc, dma_rvalid, pend_d); else n_pass++;
      n_checks++; if (cpu_rdata !== (pend_c ? pend_data : 8'h00)) $display("FAIL rnd_cpu_rdata cyc%0d: got %h want %h", cyc, cpu_rdata, pend_c ? pend_data : 8'h00); else n_pass++;
      n_checks++; if (dma_rdata !== (pend_d ? pend_data : 8'h00)) $display("FAIL rnd_dma_rdata cyc%0d: got %h want %h", cyc, dma_rdata, pend_d ? pend_data : 8'h00); else n_pass++;
      n_checks++; if (oor_err !== pend_oor) $display("FAIL rnd_oor_err cyc%0d: got %b want %b", cyc, oor_err, pend_oor); else n_pass++;
      n_checks++; if (m_unl > MAX_WAIT || (dma_req && !dma_gnt && m_owner == 0 && m_unl == MAX_WAIT)) $display("FAIL rnd_dma_starve cyc%0d: got %0d unlocked waits want <= %0d", cyc, m_unl + 1, MAX_WAIT); else n_pass++;
      @(posedge clk);
      // Model update with the inputs of the cycle just sampled.
      pend_c = cg && !cpu_we;
      pend_d = dg && !dma_we;
      pend_oor = (cg || dg) && !inr;
      pend_data = 8'h00;
      if ((cg || dg) && inr) begin
        if (dg ? dma_we : cpu_we) ref_mem[a[8:0]] = dg ? dma_wdata : cpu_wdata;
        else                      pend_data = ref_mem[a[8:0]];
      end
      if (dg) m_unl = 0;
      else if (dma_req && m_owner == 0) m_unl++;
      if (m_owner == 0) begin
        if (cg && cpu_lock)      m_owner = 1;
        else if (dg && dma_lock) m_owner = 2;
      end else if (m_owner == 1 && !cpu_lock) m_owner = 0;
      else if (m_owner == 2 && !dma_lock)     m_owner = 0;
      if (dg)           m_wait = 0;
      else if (dma_req) m_wait++;
      c_stall = cpu_req && !cg;
      d_stall = dma_req && !dg;
      #1;
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_contention();
    test_lock();
    test_oor();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
